// File: rtl/servo_scheduler.sv
// servo_scheduler: N-channel servo PWM generator on a shared frame.
// Each channel holds a target pulse width written through a valid/ready
// command port. Its current width walks toward that target by at most SLEW
// cycles per frame, so a servo never jumps. All outputs are registered.
module servo_scheduler #(
    parameter int N        = 4,
    parameter int FRAME    = 1000000,
    parameter int MIN_W    = 25000,
    parameter int STEP_W   = 392,
    parameter int SLEW     = 10000,
    parameter int INIT_POS = 128
) (
    input  logic         CLOCK_50,
    input  logic         reset,
    input  logic         enable,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_chan,
    input  logic [7:0]   cmd_pos,
    output logic [N-1:0] servo_pwm,
    output logic         frame_tick,
    output logic         busy
);

    localparam logic [19:0] FRAME_LAST = 20'(FRAME - 1);
    localparam logic [19:0] MIN_W_C    = 20'(MIN_W);
    localparam logic [19:0] STEP_W_C   = 20'(STEP_W);
    localparam logic [19:0] SLEW_C     = 20'(SLEW);
    localparam logic [19:0] INIT_W     = 20'(MIN_W + INIT_POS * STEP_W);

    // Position to pulse width, kept at 20 bits like the frame counter.
    function automatic logic [19:0] pos_to_width(input logic [7:0] pos);
        return MIN_W_C + ({12'd0, pos} * STEP_W_C);
    endfunction

    // One frame's move of the current width toward the target. The move is
    // clamped so that the width lands exactly on the target, never past it.
    function automatic logic [19:0] slew_step(input logic [19:0] cur,
                                              input logic [19:0] tgt);
        logic [19:0] res;
        if (tgt > cur) begin
            res = ((tgt - cur) > SLEW_C) ? (cur + SLEW_C) : tgt;
        end else if (tgt < cur) begin
            res = ((cur - tgt) > SLEW_C) ? (cur - SLEW_C) : tgt;
        end else begin
            res = cur;
        end
        return res;
    endfunction

    logic [19:0]  cnt_q, cnt_d;
    logic         run_q;            // enable seen on the previous edge
    logic         tick_q, tick_d;
    logic         rdy_q, rdy_d;
    logic         busy_q, busy_d;
    logic [N-1:0] pwm_q, pwm_d;
    logic [19:0]  cur_w_q [N];
    logic [19:0]  cur_w_d [N];
    logic [19:0]  tgt_w_q [N];
    logic [19:0]  tgt_w_d [N];
    logic         slew_s;
    logic         accept_s;
    logic [19:0]  new_w_s;

    // Next-state logic: frame counter, slew update, command write, PWM compare.
    always_comb begin
        slew_s   = enable & tick_q;
        accept_s = cmd_valid & rdy_q;
        new_w_s  = pos_to_width(cmd_pos);

        // The first enabled edge after a pause (or reset) opens a frame at 0,
        // so the pulse that rises on that edge is a full one.
        if (!enable) begin
            cnt_d = 20'd0;
        end else if (!run_q) begin
            cnt_d = 20'd0;
        end else if (cnt_q == FRAME_LAST) begin
            cnt_d = 20'd0;
        end else begin
            cnt_d = cnt_q + 20'd1;
        end

        // Ready is withdrawn during the last frame cycle so a command write
        // never lands on the same edge as the slew update.
        tick_d = (cnt_d == FRAME_LAST);
        rdy_d  = (cnt_d != FRAME_LAST);

        cur_w_d = cur_w_q;
        tgt_w_d = tgt_w_q;
        pwm_d   = {N{1'b0}};
        busy_d  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (slew_s) begin
                cur_w_d[i] = slew_step(cur_w_q[i], tgt_w_q[i]);
            end else begin
                cur_w_d[i] = cur_w_q[i];
            end
            // Channel indices >= N match nothing: the command is dropped.
            if (accept_s && (cmd_chan == 3'(i))) begin
                tgt_w_d[i] = new_w_s;
            end else begin
                tgt_w_d[i] = tgt_w_q[i];
            end
            pwm_d[i] = enable & (cnt_d < cur_w_d[i]);
            busy_d   = busy_d | (cur_w_d[i] != tgt_w_d[i]);
        end
    end

    // State registers; reset clears the pulses at once and reloads all widths.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            cnt_q  <= 20'd0;
            run_q  <= 1'b0;
            tick_q <= 1'b0;
            rdy_q  <= 1'b0;
            busy_q <= 1'b0;
            pwm_q  <= {N{1'b0}};
            for (int i = 0; i < N; i++) begin
                cur_w_q[i] <= INIT_W;
                tgt_w_q[i] <= INIT_W;
            end
        end else begin
            cnt_q  <= cnt_d;
            run_q  <= enable;
            tick_q <= tick_d;
            rdy_q  <= rdy_d;
            busy_q <= busy_d;
            pwm_q  <= pwm_d;
            for (int i = 0; i < N; i++) begin
                cur_w_q[i] <= cur_w_d[i];
                tgt_w_q[i] <= tgt_w_d[i];
            end
        end
    end

    assign servo_pwm  = pwm_q;
    assign frame_tick = tick_q;
    assign cmd_ready  = rdy_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_servo_scheduler.sv
// Self-checking bench for servo_scheduler with a scaled-down frame.
// The reference model tracks per-channel current and target widths as plain
// integers, steps them once per frame, and predicts every PWM sample.
module tb_servo_scheduler;

    localparam int N        = 4;
    localparam int FRAME    = 2000;
    localparam int MIN_W    = 50;
    localparam int STEP_W   = 4;
    localparam int SLEW     = 100;
    localparam int INIT_POS = 128;
    localparam int INIT_W   = MIN_W + INIT_POS * STEP_W;

    logic         clk       = 1'b0;
    logic         reset     = 1'b0;
    logic         enable    = 1'b0;
    logic         cmd_valid = 1'b0;
    logic [2:0]   cmd_chan  = 3'd0;
    logic [7:0]   cmd_pos   = 8'd0;
    logic         cmd_ready;
    logic [N-1:0] servo_pwm;
    logic         frame_tick;
    logic         busy;

    typedef struct {
        int k;
        int chan;
        int pos;
    } cmd_t;

    cmd_t cmd_q[$];
    int   model_cur [N];
    int   model_tgt [N];
    int   n_checks   = 0;
    int   n_pass     = 0;
    int   issued     = 0;
    int   acc_cnt    = 0;
    int   last_acc_k = -1;
    bit   acc_flag   = 1'b0;

    always #5 clk = ~clk;

    servo_scheduler #(
        .N(N), .FRAME(FRAME), .MIN_W(MIN_W), .STEP_W(STEP_W),
        .SLEW(SLEW), .INIT_POS(INIT_POS)
    ) dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .enable    (enable),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_chan  (cmd_chan),
        .cmd_pos   (cmd_pos),
        .servo_pwm (servo_pwm),
        .frame_tick(frame_tick),
        .busy      (busy)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            model_cur[c] = INIT_W;
            model_tgt[c] = INIT_W;
        end
    endtask

    // Each frame boundary moves every width toward its target by <= SLEW.
    task automatic model_frame_end();
        for (int c = 0; c < N; c++) begin
            if (model_tgt[c] > model_cur[c])
                model_cur[c] = (model_tgt[c] - model_cur[c] > SLEW) ? model_cur[c] + SLEW : model_tgt[c];
            else if (model_tgt[c] < model_cur[c])
                model_cur[c] = (model_cur[c] - model_tgt[c] > SLEW) ? model_cur[c] - SLEW : model_tgt[c];
        end
    endtask

    function automatic int exp_mask(input int k);
        int m = 0;
        for (int c = 0; c < N; c++)
            if (k < model_cur[c]) m = m | (1 << c);
        return m;
    endfunction

    task automatic push_cmd(input int k, input int chan, input int pos);
        cmd_t e;
        e.k = k; e.chan = chan; e.pos = pos;
        cmd_q.push_back(e);
        issued++;
    endtask

    // Called once per negedge: retire an accepted command, present the next
    // queued one, and record a handshake that will complete on the next edge.
    task automatic drive_cmd(input int k);
        int ch;
        if (acc_flag) begin
            cmd_valid = 1'b0;
            acc_flag  = 1'b0;
        end
        if (!cmd_valid && cmd_q.size() > 0 && cmd_q[0].k <= k) begin
            cmd_chan  = 3'(cmd_q[0].chan);
            cmd_pos   = 8'(cmd_q[0].pos);
            cmd_valid = 1'b1;
            void'(cmd_q.pop_front());
        end
        if (cmd_valid && cmd_ready) begin
            acc_flag   = 1'b1;
            acc_cnt++;
            last_acc_k = k;
            ch = int'(cmd_chan);
            if (ch < N) model_tgt[ch] = MIN_W + int'(cmd_pos) * STEP_W;
        end
    endtask

    // One full frame, entered at the negedge before the frame-start edge.
    task automatic run_frame(input string tag);
        int   w [N];
        int   shape_bad = 0, tick_cnt = 0, tick_pos = -1, rdy_bad = 0, busy_bad = 0;
        logic exp_busy;
        for (int c = 0; c < N; c++) w[c] = 0;
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            exp_busy = 1'b0;
            for (int c = 0; c < N; c++) begin
                if (model_cur[c] != model_tgt[c]) exp_busy = 1'b1;
                if (servo_pwm[c] === 1'b1) w[c]++;
                if (servo_pwm[c] !== (k < model_cur[c])) shape_bad++;
            end
            if (frame_tick === 1'b1) begin
                tick_cnt++;
                tick_pos = k;
            end
            if (cmd_ready !== (k != FRAME - 1)) rdy_bad++;
            if (busy !== exp_busy) busy_bad++;
            drive_cmd(k);
        end
        for (int c = 0; c < N; c++)
            chk($sformatf("%s width ch%0d", tag, c), w[c], model_cur[c]);
        chk({tag, " pulse shape errors"}, shape_bad, 0);
        chk({tag, " tick count"}, tick_cnt, 1);
        chk({tag, " tick position"}, tick_pos, FRAME - 1);
        chk({tag, " ready errors"}, rdy_bad, 0);
        chk({tag, " busy errors"}, busy_bad, 0);
        model_frame_end();
    endtask

    initial begin
        int kk, n, off_bad;

        // Reset state
        #1 reset = 1'b1;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset pwm", int'(servo_pwm), 0);
        chk("reset tick", int'(frame_tick), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset ready", int'(cmd_ready), 0);
        reset = 1'b0;
        model_reset();

        // Idle frames at the initial width
        run_frame("t1 f0");
        run_frame("t1 f1");

        // Upward ramp to the maximum position
        push_cmd(10, 0, 255);
        for (int f = 0; f < 7; f++) run_frame($sformatf("t2 f%0d", f));

        // Downward ramp ending on a partial step
        push_cmd(5, 1, 0);
        for (int f = 0; f < 7; f++) run_frame($sformatf("t3 f%0d", f));

        // Command presented in the last frame cycle waits one edge
        push_cmd(FRAME - 1, 3, 200);
        run_frame("t4 f0");
        chk("t4 not accepted in tick cycle", acc_cnt, issued - 1);
        run_frame("t4 f1");
        chk("t4 accepted at frame start", last_acc_k, 0);
        run_frame("t4 f2");

        // Mid-frame command, then an out-of-range channel back to back
        push_cmd(60, 2, 0);
        push_cmd(61, 5, 99);
        run_frame("t5 f0");
        chk("t5 both handshakes done", acc_cnt, issued);
        run_frame("t5 f1");

        // Randomized command traffic
        for (int f = 0; f < 5; f++) begin
            n  = $urandom_range(0, 3);
            kk = $urandom_range(0, 400);
            for (int j = 0; j < n; j++) begin
                push_cmd(kk, $urandom_range(0, 7), $urandom_range(0, 255));
                kk = kk + $urandom_range(0, 600);
                if (kk > FRAME - 1) kk = FRAME - 1;
            end
            run_frame($sformatf("rand f%0d", f));
        end
        run_frame("drain");
        chk("drain idle", cmd_q.size() + int'(cmd_valid), 0);
        chk("drain accept count", acc_cnt, issued);

        // enable dropped mid-pulse, command while paused, then restart
        for (int k = 0; k <= 80; k++) begin
            @(negedge clk);
            drive_cmd(k);
            if (k == 80) chk("t6 pwm before drop", int'(servo_pwm), exp_mask(80));
        end
        enable = 1'b0;
        @(negedge clk);
        chk("t6 pwm off next edge", int'(servo_pwm), 0);
        push_cmd(0, 1, 50);
        off_bad = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (servo_pwm !== '0 || frame_tick !== 1'b0 || cmd_ready !== 1'b1) off_bad++;
            drive_cmd(0);
        end
        chk("t6 paused outputs", off_bad, 0);
        chk("t6 paused command accepted", acc_cnt, issued);
        enable = 1'b1;
        run_frame("t6 re-enable");

        // Asynchronous reset in the middle of the pulses
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            drive_cmd(k);
            if (k == 20) chk("t6 pwm before reset", int'(servo_pwm), exp_mask(20));
        end
        #2 reset = 1'b1;
        #1;
        chk("t6 pwm cleared without edge", int'(servo_pwm), 0);
        chk("t6 busy cleared", int'(busy), 0);
        chk("t6 ready cleared", int'(cmd_ready), 0);
        repeat (2) @(negedge clk);
        reset     = 1'b0;
        cmd_valid = 1'b0;
        acc_flag  = 1'b0;
        cmd_q.delete();
        model_reset();
        run_frame("t6 post-reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
